// File: rtl/jtdd_obj_romrq.sv
// Object ROM read responder: serves 16-bit object-engine reads from a
// 2-line cache of 32-bit SDRAM words, fetching on a miss.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   addr, addr_ok   word address and request valid from the object engine
//   dout, data_ok   registered word for the current addr and its ok flag
//   sdram_addr      22-bit SDRAM word address, always even
//   sdram_req       fetch request, held until sdram_ack
//   sdram_ack       one-cycle pulse: request accepted
//   sdram_dok       one-cycle pulse: sdram_din valid
//   sdram_din       fetched data, [15:0] even word, [31:16] odd word
//
// Optional feature macro: JTDD_OBJ_ROMRQ_PREFETCH_EN
//   When defined, each demand fill is followed by one prefetch of the
//   next line (tag+1) into the line that was not just filled.
module jtdd_obj_romrq #(
  parameter int          AW     = 19,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          addr_ok,
  output logic [15:0]   dout,
  output logic          data_ok,
  output logic [21:0]   sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_dok,
  input  logic [31:0]   sdram_din
);

  localparam int TW = AW - 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t st, nxt;

  logic [1:0]          valid;
  logic [1:0][TW-1:0]  tags;
  logic [1:0][31:0]    lines;
  logic                ptr;
  logic [TW-1:0]       miss_tag;
  logic [TW-1:0]       req_tag;
  logic [TW-1:0]       issue_tag;
  logic [21:0]         issue_addr;

  logic        hit0, hit1, hit;
  logic        miss;
  logic        issue;
  logic        fill;
  logic        fill_line;
  logic [31:0] sel;
  logic [15:0] word;

`ifdef JTDD_OBJ_ROMRQ_PREFETCH_EN
  logic          pf_pend;
  logic [TW-1:0] pf_tag;
  logic          pf_line;
  logic          in_pf;
  logic          pf_cached;
  logic          pf_issue;
`endif

  assign req_tag = addr[AW-1:1];

  assign hit0 = valid[0] && (tags[0] == req_tag);
  assign hit1 = valid[1] && (tags[1] == req_tag);
  assign hit  = addr_ok && (hit0 || hit1);
  assign miss = addr_ok && !hit;

  assign sel  = hit0 ? lines[0] : lines[1];
  assign word = addr[0] ? sel[31:16] : sel[15:0];

  assign sdram_req = (st == REQ);

`ifdef JTDD_OBJ_ROMRQ_PREFETCH_EN
  assign pf_cached = (valid[0] && (tags[0] == pf_tag))
                  || (valid[1] && (tags[1] == pf_tag));
  assign issue_tag = pf_issue ? pf_tag : req_tag;
`else
  assign issue_tag = req_tag;
`endif

  // 22-bit sum wraps naturally modulo 2^22
  assign issue_addr = OFFSET + 22'({issue_tag, 1'b0});

  // An empty line is always preferred over evicting a live one
  always_comb begin
    if (!valid[0]) begin
      fill_line = 1'b0;
    end else if (!valid[1]) begin
      fill_line = 1'b1;
    end else begin
      fill_line = ptr;
    end
`ifdef JTDD_OBJ_ROMRQ_PREFETCH_EN
    if (in_pf) fill_line = pf_line;
`endif
  end

  always_comb begin
    nxt   = st;
    issue = 1'b0;
    fill  = 1'b0;
`ifdef JTDD_OBJ_ROMRQ_PREFETCH_EN
    pf_issue = 1'b0;
`endif
    unique case (st)
      IDLE: begin
        if (miss) begin
          issue = 1'b1;
          nxt   = REQ;
        end
`ifdef JTDD_OBJ_ROMRQ_PREFETCH_EN
        else if (pf_pend && !pf_cached) begin
          pf_issue = 1'b1;
          issue    = 1'b1;
          nxt      = REQ;
        end
`endif
      end
      REQ: begin
        if (sdram_ack) begin
          if (sdram_dok) begin
            fill = 1'b1;
            nxt  = IDLE;
          end else begin
            nxt  = WAIT;
          end
        end
      end
      WAIT: begin
        if (sdram_dok) begin
          fill = 1'b1;
          nxt  = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      valid      <= '0;
      tags       <= '0;
      lines      <= '0;
      ptr        <= 1'b0;
      miss_tag   <= '0;
      sdram_addr <= '0;
      data_ok    <= 1'b0;
      dout       <= '0;
    end else begin
      st      <= nxt;
      data_ok <= hit;
      if (hit) dout <= word;
      if (issue) begin
        miss_tag   <= issue_tag;
        sdram_addr <= issue_addr;
      end
      if (fill) begin
        valid[fill_line] <= 1'b1;
        tags[fill_line]  <= miss_tag;
        lines[fill_line] <= sdram_din;
        ptr              <= ~ptr;
      end
    end
  end

`ifdef JTDD_OBJ_ROMRQ_PREFETCH_EN
  // Pending prefetch lives for one IDLE cycle; a demand miss there wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_pend <= 1'b0;
      pf_tag  <= '0;
      pf_line <= 1'b0;
      in_pf   <= 1'b0;
    end else begin
      if (st == IDLE) pf_pend <= 1'b0;
      if (issue) in_pf <= pf_issue;
      if (fill) begin
        in_pf <= 1'b0;
        if (!in_pf) begin
          pf_pend <= 1'b1;
          pf_tag  <= miss_tag + 1'b1;
          pf_line <= ~fill_line;
        end
      end
    end
  end
`endif

endmodule

// File: doc/jtdd_obj_romrq.md
Name: jtdd_obj_romrq

Overview:
- Responder side of the object-layer ROM fetch interface.
- The object engine drives a 19-bit word address and waits for a 16-bit word with an ok flag. This block serves those reads from a small 2-line cache.
- On a miss it issues a 32-bit SDRAM burst through a req/ack/data-valid handshake.
- Sits between the object engine and the SDRAM arbiter slot in the game top level.

Parameters:
- AW, 19, word address width from the object engine.
- OFFSET, 22'h0, SDRAM word base address of the object ROM region; added to the requested address.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- addr  in  AW  16-bit-word address requested by the object engine
- addr_ok  in  1  request valid; when low no fetch is started
- dout  out  16  returned ROM word
- data_ok  out  1  high when dout holds the word for the current addr
- sdram_addr  out  22  SDRAM word address, always even (32-bit aligned)
- sdram_req  out  1  fetch request
- sdram_ack  in  1  one-cycle pulse: arbiter accepted the request
- sdram_dok  in  1  one-cycle pulse: sdram_din valid
- sdram_din  in  32  fetched data; [15:0] = even word, [31:16] = odd word

Interface: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Cache organisation
  - Two lines, each with a valid bit, an 18-bit tag (= addr[18:1]) and 32 data bits.
  - Word select is addr[0]: 0 picks data[15:0], 1 picks data[31:16].
- Hit detection
  - hit = addr_ok and a valid line whose tag equals addr[18:1].
  - data_ok and dout are registered: one clock after addr/addr_ok are stable on a hit, data_ok=1 and dout = the selected word.
  - When addr changes to a non-hit address, data_ok drops on the next clock.
- Reset
  - Both valid bits cleared; victim pointer=0; state=IDLE.
  - Outputs: data_ok=0, dout=0, sdram_req=0, sdram_addr=0.
  - A reset mid-fetch abandons the fetch; a later sdram_dok is ignored, since state is no longer WAIT.
- FSM
  - IDLE: if addr_ok and not hit → latch miss_tag=addr[18:1]; sdram_addr = OFFSET + {addr[18:1],1'b0} (22-bit, wrap-around modulo 2^22); sdram_req=1; go to REQ.
  - REQ: hold sdram_req=1 and sdram_addr constant until sdram_ack; then sdram_req=0 and go to WAIT. If sdram_ack and sdram_dok arrive in the same cycle, go straight to FILL behaviour (write the line, return to IDLE).
  - WAIT: on sdram_dok, write sdram_din into the victim line with tag=miss_tag, set its valid bit, toggle the victim pointer, return to IDLE.
  - Victim selection: if one line is invalid, that line is the victim; otherwise round-robin pointer.
- Address change during a fetch: the fetch always completes and fills the cache. data_ok stays 0 until the (new) addr hits. A new miss is issued from IDLE on the cycle after the fill.
- Hit latency is 1 clock.
- Miss latency = 1 (IDLE) + arbiter ack delay + data delay + 1 (fill) + 1 (registered hit).
- Repeated requests for the same line never issue a second SDRAM fetch while the line stays valid.
- addr_ok low: no new fetch; an in-flight fetch still completes; data_ok=0.

Optional Feature:
- Macro: JTDD_OBJ_ROMRQ_PREFETCH_EN.
- With the macro defined:
  - After each demand fill, if no demand miss is pending and line tag+1 (18-bit wrap) is not cached, the FSM issues one prefetch of tag+1 into the other line.
  - A demand miss arriving during a prefetch waits for the prefetch to complete.
  - A prefetch never evicts the line just filled.
- Without the macro: only demand misses fetch; the behaviour is exactly as above.

Test Plan:
- Reset release, addr=0, addr_ok=1, ack after 2 clk, dok with 32'hBEEF_1234 after 3 more → sdram_addr=0, one sdram_req pulse train; data_ok=1, dout=16'h1234. Then addr=1 → next clk data_ok=1, dout=16'hBEEF, no sdram_req.
- OFFSET=22'h10_0000, addr=19'h7FFFF → sdram_addr=22'h17_FFFE; on fill, dout = sdram_din[31:16].
- Three distinct lines (tags 0,1,2) in sequence, then tag 0 again → fourth access misses, because tag 0 was evicted by round-robin; tag 2 still hits.
- addr changed from 19'h00010 to 19'h00020 while in WAIT → line 0x8 still filled, data_ok stays 0, then fetch for line 0x10 starts the cycle after the fill; data_ok=1 once it completes.
- rst asserted while in WAIT, then sdram_dok pulse → no valid bit set, data_ok=0, sdram_req=0; the next request to the same addr misses.
- PREFETCH_EN: demand addr=19'h00040 → after its fill, a second request with sdram_addr=22'h42 appears; addr=19'h00042 then hits with no further sdram_req.
